// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined datapath.
//
// Owns the byte-addressed program counter, drives the word address into an
// asynchronous-read instruction ROM and registers the returned instruction and
// PC+4 into the IF/ID pipeline register. Handles hazard stalls, IF/ID flushes
// and branch/jump redirects with wrong-path squash.
//
// Optional feature (macro FETCH_HALT_EN): adds output `halted` and a RUN/HALTED
// FSM. Fetching the all-ones word stops the stage until reset.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   stall          hold PC and IF/ID
//   flush          squash IF/ID, PC still advances (held if stall is also set)
//   branch_taken   EX-resolved taken branch, redirect to branch_target
//   branch_target  branch destination (bits [1:0] ignored)
//   jump           ID-decoded jump, redirect to jump_target
//   jump_target    jump destination (bits [1:0] ignored)
//   imem_addr      word address into instruction memory (pc[ADDR_WIDTH+1:2])
//   imem_data      instruction at imem_addr, same cycle
//   pc             current fetch PC
//   if_id_instr    registered instruction (0 = NOP when squashed)
//   if_id_pc4      registered PC+4 of that instruction
//   if_id_valid    IF/ID holds a real instruction
//   halted         (FETCH_HALT_EN only) stage is halted
module fetch_stage #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  jump,
  input  logic [PC_WIDTH-1:0]   jump_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]   if_id_pc4,
`ifdef FETCH_HALT_EN
  output logic                  if_id_valid,
  output logic                  halted
`else
  output logic                  if_id_valid
`endif
);

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]   pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic                  squash;
  logic                  halt_active;

  // Wraps modulo 2**PC_WIDTH by width truncation.
  assign pc_plus4  = pc_q + PC_WIDTH'(4);
  // Upper PC bits are dropped, so the ROM address wraps modulo 2**ADDR_WIDTH.
  assign imem_addr = pc_q[ADDR_WIDTH+1:2];

`ifdef FETCH_HALT_EN
  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StHalted = 1'b1;

  logic [0:0] state_q, state_d;

  assign halt_active = (state_q == StHalted);
  assign halted      = halt_active;

  // Only an edge that captures normally can enter HALTED; the halt word itself
  // is still delivered to decode on that edge.
  always_comb begin
    state_d = state_q;
    if ((state_q == StRun) && !branch_taken && !jump && !flush && !stall &&
        (imem_data == {DATA_WIDTH{1'b1}})) begin
      state_d = StHalted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign halt_active = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    squash  = 1'b0;
    if (halt_active) begin
      // PC frozen, decode sees NOPs; all control inputs ignored.
      squash = 1'b1;
    end else if (branch_taken) begin
      // Older EX branch wins over ID jump; the stalled ID instruction is wrong-path.
      pc_d   = {branch_target[PC_WIDTH-1:2], 2'b00};
      squash = 1'b1;
    end else if (jump) begin
      pc_d   = {jump_target[PC_WIDTH-1:2], 2'b00};
      squash = 1'b1;
    end else if (flush) begin
      if (!stall) begin
        pc_d = pc_plus4;
      end
      squash = 1'b1;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      instr_d = imem_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
    if (squash) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random phase,
// each edge's expected IF state is pushed to a scoreboard queue and compared
// after the edge. Define FETCH_HALT_EN to also exercise the halt feature.
module tb_fetch_stage;

  localparam int unsigned AW = 6;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic          jump;
  logic [31:0]   jump_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   pc;
  logic [31:0]   if_id_instr;
  logic [31:0]   if_id_pc4;
  logic          if_id_valid;
`ifdef FETCH_HALT_EN
  logic          halted;
`endif

  logic [31:0] mem [2**AW];

  fetch_stage #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .PC_WIDTH   (32)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
`ifdef FETCH_HALT_EN
    .if_id_valid   (if_id_valid),
    .halted        (halted)
`else
    .if_id_valid   (if_id_valid)
`endif
  );

  // Asynchronous-read ROM.
  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc4   = '0;
  logic        m_valid = 1'b0;
  logic        m_halt  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge with the given inputs.
  task automatic model_edge(input logic rst, input logic stl, input logic fl, input logic br,
                            input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    logic [31:0] seq;
    logic [31:0] word;
    seq  = m_pc + 32'd4;
    word = mem[m_pc[AW+1:2]];
    if (rst) begin
      m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (br) begin
      m_pc = {bt[31:2], 2'b00}; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (jp) begin
      m_pc = {jt[31:2], 2'b00}; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (fl) begin
      if (!stl) m_pc = seq;
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (!stl) begin
      m_instr = word; m_pc4 = seq; m_valid = 1'b1; m_pc = seq;
`ifdef FETCH_HALT_EN
      if (word == 32'hFFFF_FFFF) m_halt = 1'b1;
`endif
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic fl, input logic br,
                      input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    exp_t e;
    exp_t got;
    reset = rst; stall = stl; flush = fl;
    branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    #1;
    if (!rst) check_eq("imem_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
    model_edge(rst, stl, fl, br, bt, jp, jt);
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.halted = m_halt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("pc", pc, got.pc);
    check_eq("instr", if_id_instr, got.instr);
    check_eq("pc4", if_id_pc4, got.pc4);
    check_eq("valid", 32'(if_id_valid), 32'(got.valid));
`ifdef FETCH_HALT_EN
    check_eq("halted", 32'(halted), 32'(got.halted));
`endif
  endtask

  task automatic step_nop();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 2**AW; k++) mem[k] = 32'h100 + 32'(k);
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    @(negedge clk);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0);
    check_eq("rst_pc_const", pc, 32'h0);
    check_eq("rst_valid_const", 32'(if_id_valid), 32'h0);

    // Sequential fetch.
    step_nop();
    check_eq("seq0_instr", if_id_instr, 32'h100);
    check_eq("seq0_valid", 32'(if_id_valid), 32'h1);
    step_nop();
    check_eq("seq1_pc", pc, 32'h8);
    check_eq("seq1_instr", if_id_instr, 32'h101);

    // Stall two cycles at pc=8.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("stall_pc", pc, 32'h8);
    check_eq("stall_instr", if_id_instr, 32'h101);
    step_nop();
    check_eq("resume_instr", if_id_instr, 32'h102);
    step_nop();
    check_eq("seq_pc16", pc, 32'h10);
    check_eq("seq_pc4_16", if_id_pc4, 32'h10);

    // Branch + stall + jump together: branch wins, target realigned.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h21, 1'b1, 32'h40);
    check_eq("br_pc", pc, 32'h20);
    check_eq("br_valid", 32'(if_id_valid), 32'h0);
    step_nop();
    check_eq("br_next_instr", if_id_instr, 32'h108);

    // Jump alone, flush, flush+stall.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h33);
    check_eq("jmp_pc", pc, 32'h30);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("flush_pc", pc, 32'h34);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("flush_stall_pc", pc, 32'h34);

    // PC wrap.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE);
    check_eq("wrap_addr", 32'(imem_addr), 32'd63);
    step_nop();
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_pc4", if_id_pc4, 32'h0);
    check_eq("wrap_instr", if_id_instr, 32'h13F);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    check_eq("addr_wrap", 32'(imem_addr), 32'h0);
    step_nop();

    // Reset mid-stall at pc=0x10.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("rst_stall_pc", pc, 32'h0);
    step_nop();
    check_eq("rst_stall_instr", if_id_instr, 32'h100);

    // Random mix.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 25),
           1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 8), $urandom(),
           1'($urandom_range(0, 99) < 8), $urandom());
    end

`ifdef FETCH_HALT_EN
    mem[2] = 32'hFFFF_FFFF;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step_nop();
    step_nop();
    step_nop();
    check_eq("halt_flag", 32'(halted), 32'h1);
    check_eq("halt_pc", pc, 32'hC);
    check_eq("halt_instr", if_id_instr, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    end
    check_eq("halt_pc_frozen", pc, 32'hC);
    check_eq("halt_valid", 32'(if_id_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("halt_cleared", 32'(halted), 32'h0);
    mem[2] = 32'h102;
`endif

    if (sb_q.size() != 0) check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
